stream_arb: RTL

- Round-robin arbiter that shares one valid/ready stream, typically the write side of a shared fifo_nd, between NREQ requesters.
- Supports multi-beat bursts: the grant is locked until the beat tagged last is accepted.
- Has a one-entry registered output stage and tags each beat with the source requester ID.
- Sits between the memory/fetch/LSU requesters and the shared request queue.

---
 rtl/stream_arb_pkg.sv | 12 +
 rtl/stream_arb_rr_pick.sv | 35 +++
 rtl/stream_arb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream arbiter family: lock state encoding and
// the largest requester count any arbiter instance supports.
package stream_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/stream_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Rotates req so ptr sits at bit 0,
// finds the first set bit, then rotates the index back.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            vld
);

    logic [2*ARB_MAX_REQ-1:0] dbl;
    logic [ARB_MAX_REQ-1:0]   rot;
    int                       first;

    always_comb begin
        dbl = '0;
        dbl[NREQ-1:0]      = req;
        dbl[2*NREQ-1:NREQ] = req;
        rot = dbl[int'(ptr) +: ARB_MAX_REQ];
        first = 0;
        // Descending scan so the lowest rotated position wins.
        for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
            if (k < NREQ && rot[k]) begin
                first = k;
            end
        end
        idx = IDW'((int'(ptr) + first) % NREQ);
        vld = |req;
    end

endmodule

// File: rtl/stream_arb.sv
// Round-robin valid/ready arbiter with burst locking and a registered output slot.
// Optional build macro STREAM_ARB_HIPRIO_EN gives requester 0 absolute priority in IDLE.
//
//   state     | meaning
//   ST_IDLE   | no burst in progress; grant follows the round-robin pick
//   ST_LOCKED | burst open; grant pinned to lock_idx until its last beat
module stream_arb
    import stream_arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*WIDTH-1:0] a_data,
    input  logic [NREQ-1:0]       a_last,
    input  logic [NREQ-1:0]       a_valid,
    output logic [NREQ-1:0]       a_ready,
    output logic [WIDTH-1:0]      b_data,
    output logic [IDW-1:0]        b_id,
    output logic                  b_last,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic                  busy
);

    lock_state_t      state, state_nxt;
    logic [IDW-1:0]   lock_idx;
    logic [IDW-1:0]   rr_ptr, rr_nxt;
    logic [IDW-1:0]   pick_idx, grant_idx;
    logic             pick_vld, grant_vld;
    logic             slot_free;
    logic             acc, acc_last;
    logic [WIDTH-1:0] acc_data;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (a_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign slot_free = !b_valid || b_ready;
    assign busy      = (state == ST_LOCKED);

    always_comb begin
        grant_idx = pick_idx;
        grant_vld = pick_vld;
        if (state == ST_LOCKED) begin
            // Pinned even while the owner idles, so bursts never interleave.
            grant_idx = lock_idx;
            grant_vld = 1'b1;
        end
`ifdef STREAM_ARB_HIPRIO_EN
        else if (a_valid[0]) begin
            grant_idx = '0;
        end
`endif
    end

    always_comb begin
        a_ready  = '0;
        acc_data = '0;
        acc_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (slot_free && grant_vld && (grant_idx == IDW'(i))) begin
                a_ready[i] = 1'b1;
            end
            if (a_ready[i] && a_valid[i]) begin
                acc_data = a_data[i*WIDTH +: WIDTH];
                acc_last = a_last[i];
            end
        end
    end

    assign acc = |(a_valid & a_ready);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        if (acc) begin
            state_nxt = acc_last ? ST_IDLE : ST_LOCKED;
            if (acc_last) begin
                rr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef STREAM_ARB_HIPRIO_EN
                if (grant_idx == '0) begin
                    rr_nxt = rr_ptr;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
            b_valid  <= 1'b0;
            b_data   <= '0;
            b_id     <= '0;
            b_last   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            if (acc) begin
                lock_idx <= grant_idx;
                b_valid  <= 1'b1;
                b_data   <= acc_data;
                b_id     <= grant_idx;
                b_last   <= acc_last;
            end else if (b_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

endmodule
